// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: boundary-mode encodings
// and the count vector type used by blocks instantiating a default-width counter.
package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    localparam int CNT_DEF_WIDTH = 8;

    typedef logic [CNT_DEF_WIDTH-1:0] cnt_vec_t;

endpackage

// File: rtl/updown_slice.sv
// One bit of the ripple incrementer/decrementer. t_in is the toggle request
// from the lower bits; t_out propagates a carry (up) or borrow (down).
module updown_slice (
    input  logic q_i,
    input  logic t_in,
    input  logic up,
    output logic nxt_i,
    output logic t_out
);

    assign nxt_i = q_i ^ t_in;
    assign t_out = t_in & (up ? q_i : ~q_i);

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down event counter with programmable limit, wrap/saturate
// boundary handling, synchronous clear, cascadable tc and a sticky ovf flag.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH:0]   t_chain;
    logic             up_evt, dn_evt, bnd_evt;
    logic             carry_out_unused;

    assign t_chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        updown_slice u_slice (
            .q_i   (q_q[i]),
            .t_in  (t_chain[i]),
            .up    (up),
            .nxt_i (step_val[i]),
            .t_out (t_chain[i+1])
        );
    end

    // The final carry/borrow is intentionally dropped: arithmetic is modulo 2^WIDTH.
    assign carry_out_unused = t_chain[WIDTH];

    assign up_evt  = up && (q_q >= limit);
    assign dn_evt  = !up && (q_q == '0);
    assign bnd_evt = up_evt || dn_evt;

    // tc looks only at enable and the current q, so it reflects the pre-load value.
    assign tc = enable && bnd_evt;

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = d;
        end else if (enable) begin
            if (bnd_evt) begin
                ovf_d = 1'b1;
            end
            if (up_evt) begin
                q_d = (sat_mode == CNT_SAT) ? limit : '0;
            end else if (dn_evt) begin
                q_d = (sat_mode == CNT_SAT) ? '0 : limit;
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= RESET_VAL;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule
